// File: rtl/gb_bus_ctrl_if.sv
// Bus-side bundle between the TV80 core, the GameBoy memory/IO fabric and gb_bus_ctrl.
interface gb_bus_ctrl_if;
    logic        CLKEN;
    logic        WAIT_n;
    logic [6:0]  mc;
    logic [6:0]  ts;
    logic        intcycle_n;
    logic        no_read;
    logic        write;
    logic        iorq;
    logic [15:0] A;
    logic [7:0]  DI;
    logic        core_wait_n;
    logic [7:0]  di_reg;
    logic        MREQ_n;
    logic        IORQ_n;
    logic        RD_n;
    logic        WR_n;
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
    logic [31:0] stat_wait;

    modport slave (
        input  CLKEN, WAIT_n, mc, ts, intcycle_n, no_read, write, iorq, A, DI,
        output core_wait_n, di_reg, MREQ_n, IORQ_n, RD_n, WR_n, stat_rd, stat_wr, stat_wait
    );

    modport master (
        output CLKEN, WAIT_n, mc, ts, intcycle_n, no_read, write, iorq, A, DI,
        input  core_wait_n, di_reg, MREQ_n, IORQ_n, RD_n, WR_n, stat_rd, stat_wr, stat_wait
    );
endinterface

// File: rtl/gb_bus_ctrl.sv
// TV80 (Mode 3) bus-cycle controller: registered strobes, per-region wait inserter, read latch.
// Optional cycle statistics are built only when GB_BUS_STATS_EN is defined.
module gb_bus_ctrl #(
    parameter int unsigned T2WRITE   = 2,
    parameter int unsigned ROM_WAITS = 0,
    parameter int unsigned IO_WAITS  = 0,
    parameter int unsigned RAM_WAITS = 0,
    parameter int unsigned M1_WAIT   = 0
) (
    input  logic         CLK_n,
    input  logic         RESET_n,
    gb_bus_ctrl_if.slave bus
);
    localparam int unsigned WCNT_W = 3;
    localparam int unsigned STAT_W = 32;
    localparam int unsigned DATA_W = 8;

    localparam logic [WCNT_W-1:0] ROM_W     = WCNT_W'(ROM_WAITS);
    localparam logic [WCNT_W-1:0] IO_W      = WCNT_W'(IO_WAITS);
    localparam logic [WCNT_W-1:0] RAM_W     = WCNT_W'(RAM_WAITS);
    localparam logic              M1_WAIT_B = 1'(M1_WAIT != 0);

    if (T2WRITE > 2) begin : g_bad_t2write
        $error("gb_bus_ctrl: T2WRITE must be 0, 1 or 2");
    end
    if (ROM_WAITS > 7 || IO_WAITS > 7 || RAM_WAITS > 7 || M1_WAIT > 1) begin : g_bad_waits
        $error("gb_bus_ctrl: wait-state parameters out of range");
    end

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAITING = 1'b1
    } wait_state_t;

    wait_state_t       r_state, w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic              r_mreq_n, r_iorq_n, r_rd_n, r_wr_n;
    logic              w_mreq_n_nxt, w_iorq_n_nxt, w_rd_n_nxt, w_wr_n_nxt;
    logic [DATA_W-1:0] r_di;
    logic              w_core_wait_n;
    logic              w_access_ok;
    logic              w_wr_strobe;
    logic [WCNT_W-1:0] w_region_waits;
    logic              w_unused;

    assign w_core_wait_n = bus.WAIT_n & (r_wcnt == '0);

    // Interrupt acknowledge never waits; opcode fetches wait only when M1_WAIT is set.
    assign w_access_ok = (~bus.no_read | bus.write) & bus.intcycle_n & (~bus.mc[0] | M1_WAIT_B);
    assign w_region_waits = bus.iorq ? IO_W : (~bus.A[15] ? ROM_W : RAM_W);

    assign w_unused = &{1'b0, bus.A[14:0], bus.mc[6:3], bus.mc[1], bus.ts[6:4], bus.ts[0]};

    // Next strobe values: all deasserted, then asserted by the current M-cycle/T-state.
    always_comb begin : p_strobe_nxt
        w_mreq_n_nxt = 1'b1;
        w_iorq_n_nxt = 1'b1;
        w_rd_n_nxt   = 1'b1;
        w_wr_n_nxt   = 1'b1;
        w_wr_strobe  = 1'b0;
        if (T2WRITE == 0) begin
            w_wr_strobe = bus.ts[2];
        end else if (T2WRITE == 1) begin
            w_wr_strobe = bus.ts[1] | (bus.ts[2] & ~w_core_wait_n);
        end else begin
            w_wr_strobe = bus.ts[1] | bus.ts[2];
        end

        if (bus.mc[0]) begin
            if (bus.ts[1] | bus.ts[2]) begin
                w_rd_n_nxt   = ~bus.intcycle_n;
                w_mreq_n_nxt = ~bus.intcycle_n;
            end else if (bus.ts[3]) begin
                w_mreq_n_nxt = 1'b0;
            end
        end else if (bus.mc[2] && !bus.intcycle_n) begin
            if (bus.ts[2]) begin
                w_iorq_n_nxt = 1'b0;
            end
        end else if ((bus.ts[1] | bus.ts[2]) && !bus.no_read && !bus.write) begin
            w_rd_n_nxt   = 1'b0;
            w_iorq_n_nxt = ~bus.iorq;
            w_mreq_n_nxt = bus.iorq;
        end else if (bus.write && w_wr_strobe) begin
            w_wr_n_nxt   = 1'b0;
            w_iorq_n_nxt = ~bus.iorq;
            w_mreq_n_nxt = bus.iorq;
        end
    end

    // Wait inserter: load the region count in T2, then count down once per enabled edge.
    always_comb begin : p_wait_nxt
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.ts[1] && w_access_ok) begin
                    w_wcnt_nxt = w_region_waits;
                    if (w_region_waits != '0) begin
                        w_state_nxt = ST_WAITING;
                    end
                end
            end
            ST_WAITING: begin
                w_wcnt_nxt = r_wcnt - WCNT_W'(1);
                if (r_wcnt == WCNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK_n or negedge RESET_n) begin : p_regs
        if (!RESET_n) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_mreq_n <= 1'b1;
            r_iorq_n <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_di     <= '0;
        end else if (bus.CLKEN) begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_mreq_n <= w_mreq_n_nxt;
            r_iorq_n <= w_iorq_n_nxt;
            r_rd_n   <= w_rd_n_nxt;
            r_wr_n   <= w_wr_n_nxt;
            if (bus.ts[3] && w_core_wait_n) begin
                r_di <= bus.DI;
            end
        end
    end

    assign bus.core_wait_n = w_core_wait_n;
    assign bus.di_reg      = r_di;
    assign bus.MREQ_n      = r_mreq_n;
    assign bus.IORQ_n      = r_iorq_n;
    assign bus.RD_n        = r_rd_n;
    assign bus.WR_n        = r_wr_n;

`ifdef GB_BUS_STATS_EN
    logic [STAT_W-1:0] r_stat_rd, r_stat_wr, r_stat_wait;

    // Free-running, wrapping event counters sampled on enabled edges.
    always_ff @(posedge CLK_n or negedge RESET_n) begin : p_stats
        if (!RESET_n) begin
            r_stat_rd   <= '0;
            r_stat_wr   <= '0;
            r_stat_wait <= '0;
        end else if (bus.CLKEN) begin
            if (!w_rd_n_nxt)    r_stat_rd   <= r_stat_rd + STAT_W'(1);
            if (!w_wr_n_nxt)    r_stat_wr   <= r_stat_wr + STAT_W'(1);
            if (!w_core_wait_n) r_stat_wait <= r_stat_wait + STAT_W'(1);
        end
    end

    assign bus.stat_rd   = r_stat_rd;
    assign bus.stat_wr   = r_stat_wr;
    assign bus.stat_wait = r_stat_wait;
`else
    assign bus.stat_rd   = '0;
    assign bus.stat_wr   = '0;
    assign bus.stat_wait = '0;
`endif
endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Directed, table-driven bench for gb_bus_ctrl using three differently parameterised instances.
module tb_gb_bus_ctrl;
    logic clk;
    logic rst_n;

    gb_bus_ctrl_if b0 ();
    gb_bus_ctrl_if b1 ();
    gb_bus_ctrl_if b2 ();

    gb_bus_ctrl #(.T2WRITE(2), .ROM_WAITS(2), .IO_WAITS(3), .RAM_WAITS(0), .M1_WAIT(0))
        u_dut0 (.CLK_n(clk), .RESET_n(rst_n), .bus(b0));
    gb_bus_ctrl #(.T2WRITE(0), .ROM_WAITS(0), .IO_WAITS(0), .RAM_WAITS(0), .M1_WAIT(0))
        u_dut1 (.CLK_n(clk), .RESET_n(rst_n), .bus(b1));
    gb_bus_ctrl #(.T2WRITE(1), .ROM_WAITS(1), .IO_WAITS(0), .RAM_WAITS(0), .M1_WAIT(1))
        u_dut2 (.CLK_n(clk), .RESET_n(rst_n), .bus(b2));

`ifdef GB_BUS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [6:0] M1 = 7'h01, M2 = 7'h02, M3 = 7'h04;
    localparam logic [6:0] T1 = 7'h01, T2 = 7'h02, T3 = 7'h04, T4 = 7'h08;

    typedef struct {
        logic [6:0]  mc;
        logic [6:0]  ts;
        logic        icn;
        logic        nr;
        logic        wr;
        logic        io;
        logic [15:0] a;
        logic [7:0]  di;
        logic [3:0]  strb;   // {MREQ_n, IORQ_n, RD_n, WR_n}
        logic        cw;
        logic [7:0]  edi;
    } vec_t;

    vec_t vecs[21];
    int   n_pass = 0;
    int   n_chk  = 0;

    logic        clken, wait_n, icn, nr, wr, io;
    logic [6:0]  mc, ts;
    logic [15:0] a;
    logic [7:0]  di;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic drive();
        b0.CLKEN = clken; b0.WAIT_n = wait_n; b0.mc = mc; b0.ts = ts; b0.intcycle_n = icn;
        b0.no_read = nr; b0.write = wr; b0.iorq = io; b0.A = a; b0.DI = di;
        b1.CLKEN = clken; b1.WAIT_n = wait_n; b1.mc = mc; b1.ts = ts; b1.intcycle_n = icn;
        b1.no_read = nr; b1.write = wr; b1.iorq = io; b1.A = a; b1.DI = di;
        b2.CLKEN = clken; b2.WAIT_n = wait_n; b2.mc = mc; b2.ts = ts; b2.intcycle_n = icn;
        b2.no_read = nr; b2.write = wr; b2.iorq = io; b2.A = a; b2.DI = di;
    endtask

    task automatic set_in(input logic [6:0] i_mc, input logic [6:0] i_ts, input logic i_icn,
                          input logic i_nr, input logic i_wr, input logic i_io,
                          input logic [15:0] i_a, input logic [7:0] i_di);
        mc = i_mc; ts = i_ts; icn = i_icn; nr = i_nr; wr = i_wr; io = i_io; a = i_a; di = i_di;
        drive();
    endtask

    task automatic set_ts(input logic [6:0] i_ts);
        ts = i_ts;
        drive();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge preceded by one disabled clock (50% CLKEN).
    task automatic step_half();
        clken = 1'b0; drive(); tick();
        clken = 1'b1; drive(); tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [6:0] i_mc, input logic [6:0] i_ts, input logic i_icn,
                                input logic i_nr, input logic i_wr, input logic i_io,
                                input logic [15:0] i_a, input logic [7:0] i_di,
                                input logic [3:0] i_strb, input logic i_cw, input logic [7:0] i_edi);
        vec_t v;
        v.mc = i_mc; v.ts = i_ts; v.icn = i_icn; v.nr = i_nr; v.wr = i_wr; v.io = i_io;
        v.a = i_a; v.di = i_di; v.strb = i_strb; v.cw = i_cw; v.edi = i_edi;
        return v;
    endfunction

    initial begin
        int wr_cnt0, wr_cnt1, wr_cnt2;

        // ROM read 0x1234 with 2 waits on instance 0
        vecs[0]  = mk(M2, T1, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b1111, 1'b1, 8'h00);
        vecs[1]  = mk(M2, T2, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b0101, 1'b0, 8'h00);
        vecs[2]  = mk(M2, T3, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b0101, 1'b0, 8'h00);
        vecs[3]  = mk(M2, T3, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b0101, 1'b1, 8'h00);
        vecs[4]  = mk(M2, T3, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b0101, 1'b1, 8'h00);
        vecs[5]  = mk(M2, T4, 1, 0, 0, 0, 16'h1234, 8'hA5, 4'b1111, 1'b1, 8'hA5);
        // opcode fetch from ROM: no internal wait, refresh MREQ in T4
        vecs[6]  = mk(M1, T1, 1, 0, 0, 0, 16'h0100, 8'h5A, 4'b1111, 1'b1, 8'hA5);
        vecs[7]  = mk(M1, T2, 1, 0, 0, 0, 16'h0100, 8'h5A, 4'b0101, 1'b1, 8'hA5);
        vecs[8]  = mk(M1, T3, 1, 0, 0, 0, 16'h0100, 8'h5A, 4'b0101, 1'b1, 8'hA5);
        vecs[9]  = mk(M1, T4, 1, 0, 0, 0, 16'h0100, 8'h5A, 4'b0111, 1'b1, 8'h5A);
        // interrupt acknowledge: IORQ only in ts[2], no wait despite IO_WAITS=3
        vecs[10] = mk(M3, T1, 0, 0, 0, 1, 16'h00FF, 8'hFF, 4'b1111, 1'b1, 8'h5A);
        vecs[11] = mk(M3, T2, 0, 0, 0, 1, 16'h00FF, 8'hFF, 4'b1111, 1'b1, 8'h5A);
        vecs[12] = mk(M3, T3, 0, 0, 0, 1, 16'h00FF, 8'hFF, 4'b1011, 1'b1, 8'h5A);
        vecs[13] = mk(M3, T4, 0, 0, 0, 1, 16'h00FF, 8'hFF, 4'b1111, 1'b1, 8'hFF);
        // IO write 0xFF40 with 3 waits
        vecs[14] = mk(M2, T1, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1111, 1'b1, 8'hFF);
        vecs[15] = mk(M2, T2, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1010, 1'b0, 8'hFF);
        vecs[16] = mk(M2, T3, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1010, 1'b0, 8'hFF);
        vecs[17] = mk(M2, T3, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1010, 1'b0, 8'hFF);
        vecs[18] = mk(M2, T3, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1010, 1'b1, 8'hFF);
        vecs[19] = mk(M2, T3, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1010, 1'b1, 8'hFF);
        vecs[20] = mk(M2, T4, 1, 0, 1, 1, 16'hFF40, 8'h3C, 4'b1111, 1'b1, 8'h3C);

        // reset state; core_wait_n follows WAIT_n
        rst_n = 1'b0; clken = 1'b1; wait_n = 1'b0;
        set_in(M2, T1, 1, 0, 0, 0, 16'h0000, 8'h00);
        #12;
        chk("reset_cw_follows_wait_low", 32'(b0.core_wait_n), 32'd0);
        wait_n = 1'b1; drive(); #1;
        chk("reset_cw_follows_wait_high", 32'(b0.core_wait_n), 32'd1);
        chk("reset_strobes", 32'({b0.MREQ_n, b0.IORQ_n, b0.RD_n, b0.WR_n}), 32'hF);
        chk("reset_di", 32'(b0.di_reg), 32'h00);
        chk("reset_stat_rd", b0.stat_rd, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            set_in(vecs[i].mc, vecs[i].ts, vecs[i].icn, vecs[i].nr, vecs[i].wr, vecs[i].io,
                   vecs[i].a, vecs[i].di);
            tick();
            chk($sformatf("vec%0d_strobes", i), 32'({b0.MREQ_n, b0.IORQ_n, b0.RD_n, b0.WR_n}),
                32'(vecs[i].strb));
            chk($sformatf("vec%0d_core_wait_n", i), 32'(b0.core_wait_n), 32'(vecs[i].cw));
            chk($sformatf("vec%0d_di_reg", i), 32'(b0.di_reg), 32'(vecs[i].edi));
        end

        // RAM write, no waits: WR_n width per T2WRITE mode
        wr_cnt0 = 0; wr_cnt1 = 0; wr_cnt2 = 0;
        set_in(M2, T1, 1, 0, 1, 0, 16'hC000, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_ts(i == 0 ? T2 : (i == 1 ? T3 : T4));
            tick();
            if (!b0.WR_n) wr_cnt0++;
            if (!b1.WR_n) wr_cnt1++;
            if (!b2.WR_n) wr_cnt2++;
            if (i == 1) chk("t2w0_ram_write_strobes", 32'({b1.MREQ_n, b1.IORQ_n, b1.RD_n, b1.WR_n}), 32'h6);
        end
        chk("t2write2_wr_cycles", 32'(wr_cnt0), 32'd2);
        chk("t2write0_wr_cycles", 32'(wr_cnt1), 32'd1);
        chk("t2write1_nowait_wr_cycles", 32'(wr_cnt2), 32'd1);

        // T2WRITE=1 with one ROM wait: strobe held through the waited ts[2]
        wr_cnt2 = 0;
        set_in(M2, T1, 1, 0, 1, 0, 16'h0100, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_ts(i == 0 ? T2 : (i == 3 ? T4 : T3));
            tick();
            if (!b2.WR_n) wr_cnt2++;
        end
        chk("t2write1_wait_wr_cycles", 32'(wr_cnt2), 32'd2);

        // external WAIT_n: passthrough when idle, load still happens, waits overlap
        set_in(M2, T1, 1, 0, 0, 0, 16'h0200, 8'h11);
        tick();
        set_ts(T2); wait_n = 1'b0; drive(); #1;
        chk("ext_wait_passthrough", 32'(b1.core_wait_n), 32'd0);
        tick();
        wait_n = 1'b1; drive(); #1;
        chk("load_with_wait_low", 32'(b0.core_wait_n), 32'd0);
        chk("no_wait_region_other_inst", 32'(b1.core_wait_n), 32'd1);
        set_ts(T3); wait_n = 1'b0; drive();
        tick();
        wait_n = 1'b1; drive(); #1;
        chk("decrement_during_ext_wait", 32'(b0.core_wait_n), 32'd0);
        tick();
        chk("wait_overlap_done", 32'(b0.core_wait_n), 32'd1);
        set_ts(T4);
        tick();
        chk("ext_wait_read_di", 32'(b0.di_reg), 32'h11);

        // asynchronous reset in the middle of a waited write
        set_in(M2, T1, 1, 0, 1, 1, 16'hFF40, 8'h3C);
        tick();
        set_ts(T2);
        tick();
        chk("pre_reset_wr_low", 32'({b0.MREQ_n, b0.IORQ_n, b0.RD_n, b0.WR_n}), 32'hA);
        chk("pre_reset_wait", 32'(b0.core_wait_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_strobes", 32'({b0.MREQ_n, b0.IORQ_n, b0.RD_n, b0.WR_n}), 32'hF);
        chk("async_reset_wcnt", 32'(b0.core_wait_n), 32'd1);
        set_in(M2, T1, 1, 0, 0, 0, 16'h0000, 8'h77);
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("post_reset_di", 32'(b0.di_reg), 32'h00);

        // five ROM reads on the ROM_WAITS=1 instance with CLKEN at 50%
        for (int k = 0; k < 5; k++) begin
            set_in(M2, T1, 1, 0, 0, 0, 16'h1234, 8'hA5);
            step_half();
            set_ts(T2);
            step_half();
            if (k == 0) begin
                clken = 1'b0; drive();
                tick(); tick();
                chk("clken_low_holds_wcnt", 32'(b2.core_wait_n), 32'd0);
                chk("clken_low_holds_rd", 32'(b2.RD_n), 32'd0);
            end
            set_ts(T3);
            step_half();
            step_half();
            set_ts(T4);
            step_half();
            clken = 1'b0; drive();
            tick(); tick();
            chk($sformatf("stat_rd_after_read%0d", k), b2.stat_rd, STATS ? 32'(3 * (k + 1)) : 32'd0);
        end
        chk("stat_rd_total", b2.stat_rd, STATS ? 32'd15 : 32'd0);
        chk("stat_wait_total", b2.stat_wait, STATS ? 32'd5 : 32'd0);
        chk("stat_wr_total", b2.stat_wr, 32'd0);
        chk("stats_read_di", 32'(b2.di_reg), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
